// File: rtl/prio_pkg.sv
// ---------------------------------------------------------------------------
// prio_pkg
//   Shared types and helpers for the prio_event_enc slice.
//   - DEFAULT_WIDTH : default number of request lines.
//   - ONEHOT_W      : width of the vector returned by onehot(). Callers
//                     size-cast the result to their own width, which caps
//                     the supported request count at ONEHOT_W.
//   - idx_t         : index type sized for DEFAULT_WIDTH.
//   - onehot()      : position -> one-hot vector.
// ---------------------------------------------------------------------------
package prio_pkg;

   parameter int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_IDX_W = $clog2(DEFAULT_WIDTH);
   localparam int ONEHOT_W = 64;

   typedef logic [DEFAULT_IDX_W-1:0] idx_t;

   // Returns a vector with only bit 'pos' set.
   function automatic logic [ONEHOT_W-1:0] onehot(input int unsigned pos);
      logic [ONEHOT_W-1:0] vec_s;
      vec_s = {{(ONEHOT_W-1){1'b0}}, 1'b1} << pos;
      return vec_s;
   endfunction

endpackage : prio_pkg

// File: rtl/prio_pick.sv
// ---------------------------------------------------------------------------
// prio_pick
//   Combinational find-first-set starting at a base position and wrapping
//   from WIDTH-1 back to 0. With base tied to 0 it is a plain lowest-index
//   priority encoder.
// Ports:
//   vec   in  WIDTH  candidate bits
//   base  in  IDX_W  position searched first
//   found out 1      at least one bit of vec is set
//   index out IDX_W  first set position at or after base (0 when none)
// ---------------------------------------------------------------------------
module prio_pick #(
   parameter int WIDTH = 8,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] vec,
   input  logic [IDX_W-1:0] base,
   output logic             found,
   output logic [IDX_W-1:0] index
);

   int pos_s;

   // Any set bit means a winner exists.
   assign found = |vec;

   // Scan from the farthest offset down to offset 0 so the nearest set bit
   // after base is written last and therefore wins.
   always_comb begin
      index = {IDX_W{1'b0}};
      pos_s = 32'sd0;
      for (int k = WIDTH - 1; k >= 0; k--) begin
         pos_s = int'(base) + k;
         if (pos_s >= WIDTH) begin
            pos_s = pos_s - WIDTH;
         end else begin
            pos_s = pos_s;
         end
         if (vec[pos_s]) begin
            index = IDX_W'(pos_s);
         end else begin
            index = index;
         end
      end
   end

endmodule : prio_pick

// File: rtl/prio_event_enc.sv
// ---------------------------------------------------------------------------
// prio_event_enc
//   Registered priority encoder with sticky request capture and a
//   valid/ready output. Request pulses are latched into a pending vector;
//   the winning index is offered on idx/valid and retired on valid && ready.
//
//   Optional feature macro: ROUND_ROBIN_EN
//     undefined : fixed priority, bit 0 highest.
//     defined   : rotating priority, search starts just after the index
//                 most recently accepted (pointer reset by clr).
//
// Ports:
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous active-low reset
//   req      in   WIDTH  request pulses, bit i sets pending[i]
//   clr      in   1      synchronous flush of all pending requests
//   ready    in   1      consumer accepts idx when valid && ready
//   idx      out  IDX_W  registered winning index
//   valid    out  1      idx is meaningful
//   pending  out  WIDTH  registered pending vector
//   dropped  out  1      one-cycle pulse: a req hit an already pending bit
// ---------------------------------------------------------------------------
module prio_event_enc
   import prio_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] req,
   input  logic             clr,
   input  logic             ready,
   output logic [IDX_W-1:0] idx,
   output logic             valid,
   output logic [WIDTH-1:0] pending,
   output logic             dropped
);

   typedef logic [IDX_W-1:0] sel_t;

   logic [WIDTH-1:0] pending_r;
   logic [WIDTH-1:0] pending_nxt_s;
   logic [WIDTH-1:0] retire_mask_s;
   sel_t             idx_r;
   sel_t             idx_nxt_s;
   logic             valid_r;
   logic             valid_nxt_s;
   logic             dropped_r;
   logic             dropped_nxt_s;
   logic             acc_s;
   logic             hold_s;
   sel_t             base_s;
   logic             pick_found_s;
   sel_t             pick_idx_s;

   // Handshake: accept retires the presented index, stall freezes it.
   assign acc_s  = valid_r & ready;
   assign hold_s = valid_r & ~ready;

   // Bit to clear on accept; a same-cycle req for that bit re-sets it below.
   always_comb begin
      if (acc_s) begin
         retire_mask_s = WIDTH'(onehot(32'(idx_r)));
      end else begin
         retire_mask_s = {WIDTH{1'b0}};
      end
   end

   // Pending update and collision detection; clr discards everything.
   always_comb begin
      if (clr) begin
         pending_nxt_s = {WIDTH{1'b0}};
         dropped_nxt_s = 1'b0;
      end else begin
         pending_nxt_s = (pending_r & ~retire_mask_s) | req;
         dropped_nxt_s = |(req & pending_r & ~retire_mask_s);
      end
   end

`ifdef ROUND_ROBIN_EN
   sel_t rr_ptr_r;
   sel_t rr_ptr_nxt_s;

   // Pointer moves past the accepted index; the search for the next winner
   // uses the updated pointer so alternation takes effect immediately.
   always_comb begin
      if (clr) begin
         rr_ptr_nxt_s = {IDX_W{1'b0}};
      end else if (acc_s) begin
         if (idx_r == IDX_W'(WIDTH - 1)) begin
            rr_ptr_nxt_s = {IDX_W{1'b0}};
         end else begin
            rr_ptr_nxt_s = idx_r + IDX_W'(32'd1);
         end
      end else begin
         rr_ptr_nxt_s = rr_ptr_r;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_r <= {IDX_W{1'b0}};
      end else begin
         rr_ptr_r <= rr_ptr_nxt_s;
      end
   end

   assign base_s = rr_ptr_nxt_s;
`else
   assign base_s = {IDX_W{1'b0}};
`endif

   prio_pick #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_pick (
      .vec   (pending_nxt_s),
      .base  (base_s),
      .found (pick_found_s),
      .index (pick_idx_s)
   );

   // Output selection: clr drops valid, a stall freezes idx/valid, otherwise
   // present the new winner; with nothing pending idx keeps its last value.
   always_comb begin
      if (clr) begin
         valid_nxt_s = 1'b0;
         idx_nxt_s   = idx_r;
      end else if (hold_s) begin
         valid_nxt_s = valid_r;
         idx_nxt_s   = idx_r;
      end else if (pick_found_s) begin
         valid_nxt_s = 1'b1;
         idx_nxt_s   = pick_idx_s;
      end else begin
         valid_nxt_s = 1'b0;
         idx_nxt_s   = idx_r;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending_r <= {WIDTH{1'b0}};
         idx_r     <= {IDX_W{1'b0}};
         valid_r   <= 1'b0;
         dropped_r <= 1'b0;
      end else begin
         pending_r <= pending_nxt_s;
         idx_r     <= idx_nxt_s;
         valid_r   <= valid_nxt_s;
         dropped_r <= dropped_nxt_s;
      end
   end

   assign idx     = idx_r;
   assign valid   = valid_r;
   assign pending = pending_r;
   assign dropped = dropped_r;

endmodule : prio_event_enc

// File: tb/tb_prio_event_enc.sv
// ---------------------------------------------------------------------------
// tb_prio_event_enc
//   Directed scenarios followed by randomized traffic, checked against a
//   behavioural model that tracks pending requests as an array of flags and
//   finds the winner with a modular search.
// ---------------------------------------------------------------------------
module tb_prio_event_enc;

   localparam int W  = 8;
   localparam int IW = $clog2(W);

   logic          clk;
   logic          rst;
   logic [W-1:0]  req;
   logic          clr;
   logic          ready;
   logic [IW-1:0] idx;
   logic          valid;
   logic [W-1:0]  pending;
   logic          dropped;

   int n_cmp;
   int n_err;

   // Reference model state.
   bit m_pend [W];
   bit m_valid;
   bit m_drop;
   int m_idx;
   int m_rr;

   prio_event_enc #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .clr     (clr),
      .ready   (ready),
      .idx     (idx),
      .valid   (valid),
      .pending (pending),
      .dropped (dropped)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] model_vec();
      logic [W-1:0] v;
      for (int i = 0; i < W; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < W; i++) m_pend[i] = 1'b0;
      m_valid = 1'b0;
      m_drop  = 1'b0;
      m_idx   = 0;
      m_rr    = 0;
   endtask

   // One clock of the specified behaviour, given the inputs present at it.
   task automatic model_step(input logic [W-1:0] r, input logic c, input logic rd);
      bit acc;
      bit keep;
      bit nxt [W];
      bit drop;
      bit any;
      int base;
      int p;
      int win;
      acc  = m_valid && rd;
      drop = 1'b0;
      any  = 1'b0;
      win  = 0;
      for (int i = 0; i < W; i++) begin
         keep   = m_pend[i] && !(acc && i == m_idx);
         nxt[i] = c ? 1'b0 : (keep || r[i]);
         if (!c && keep && r[i]) drop = 1'b1;
      end
      if (c) m_rr = 0;
      else if (acc) m_rr = (m_idx + 1) % W;
`ifdef ROUND_ROBIN_EN
      base = m_rr;
`else
      base = 0;
`endif
      for (int k = W - 1; k >= 0; k--) begin
         p = (base + k) % W;
         if (nxt[p]) begin
            win = p;
            any = 1'b1;
         end
      end
      if (c) m_valid = 1'b0;
      else if (!(m_valid && !rd)) begin
         m_valid = any;
         if (any) m_idx = win;
      end
      for (int i = 0; i < W; i++) m_pend[i] = nxt[i];
      m_drop = drop;
   endtask

   task automatic check_all(input string pfx);
      chk_eq({pfx, "_valid"},   32'(valid),   32'(m_valid));
      chk_eq({pfx, "_idx"},     32'(idx),     32'(m_idx));
      chk_eq({pfx, "_pending"}, 32'(pending), 32'(model_vec()));
      chk_eq({pfx, "_dropped"}, 32'(dropped), 32'(m_drop));
   endtask

   // Drive one cycle of inputs, advance DUT and model, compare.
   task automatic cyc(input logic [W-1:0] r, input logic c, input logic rd);
      req   = r;
      clr   = c;
      ready = rd;
      @(posedge clk);
      #1;
      model_step(r, c, rd);
      check_all("cyc");
   endtask

   initial begin
      logic [W-1:0] r;
      logic         c;
      logic         rd;
      n_cmp = 0;
      n_err = 0;
      req   = 8'h00;
      clr   = 1'b0;
      ready = 1'b0;
      rst   = 1'b1;
      model_reset();

      // Reset asserted while every request line is high.
      #3;
      req = 8'hFF;
      rst = 1'b0;
      #1;
      check_all("rst_async");
      repeat (2) begin
         @(posedge clk);
         #1;
         check_all("rst_held");
      end
      rst = 1'b1;
      req = 8'h00;
      cyc(8'h00, 1'b0, 1'b0);
      cyc(8'h00, 1'b0, 1'b0);
      chk_eq("rst_idle_valid", 32'(valid), 32'd0);

      // Fixed order 2,5,7 with ready high.
      cyc(8'hA4, 1'b0, 1'b1);
      chk_eq("prio_idx2", 32'(idx), 32'd2);
      cyc(8'h00, 1'b0, 1'b1);
      chk_eq("prio_idx5", 32'(idx), 32'd5);
      cyc(8'h00, 1'b0, 1'b1);
      chk_eq("prio_idx7", 32'(idx), 32'd7);
      cyc(8'h00, 1'b0, 1'b1);
      chk_eq("prio_empty", 32'(valid), 32'd0);

      // Hold while stalled, even against a higher-priority arrival.
      cyc(8'h80, 1'b0, 1'b0);
      chk_eq("hold_idx7", 32'(idx), 32'd7);
      cyc(8'h01, 1'b0, 1'b0);
      chk_eq("hold_frozen", 32'(idx), 32'd7);
      chk_eq("hold_pend", 32'(pending), 32'h81);
      cyc(8'h00, 1'b0, 1'b1);
      chk_eq("hold_next0", 32'(idx), 32'd0);
      cyc(8'h00, 1'b0, 1'b1);

      // Collision on a pending bit, then set-wins-over-retire.
      cyc(8'h08, 1'b0, 1'b0);
      cyc(8'h08, 1'b0, 1'b0);
      chk_eq("coll_drop", 32'(dropped), 32'd1);
      chk_eq("coll_pend", 32'(pending), 32'h08);
      cyc(8'h00, 1'b0, 1'b0);
      chk_eq("coll_drop_pulse", 32'(dropped), 32'd0);
      cyc(8'h08, 1'b0, 1'b1);
      chk_eq("coll_acc_pend", 32'(pending), 32'h08);
      chk_eq("coll_acc_drop", 32'(dropped), 32'd0);
      cyc(8'h00, 1'b0, 1'b1);

      // Flush beats a simultaneous request.
      cyc(8'hF0, 1'b0, 1'b0);
      cyc(8'h01, 1'b1, 1'b0);
      chk_eq("flush_pend", 32'(pending), 32'h00);
      chk_eq("flush_valid", 32'(valid), 32'd0);
      chk_eq("flush_drop", 32'(dropped), 32'd0);

      // Two sources held active with ready high.
      for (int i = 0; i < 6; i++) begin
         cyc(8'h81, 1'b0, 1'b1);
`ifdef ROUND_ROBIN_EN
         chk_eq("rr_alt", 32'(idx), (i % 2 == 0) ? 32'd0 : 32'd7);
`else
         chk_eq("fixed_idx0", 32'(idx), 32'd0);
`endif
      end
      cyc(8'h00, 1'b1, 1'b0);

      // Randomized traffic with occasional flush and mid-run reset.
      for (int n = 0; n < 600; n++) begin
         r  = W'($urandom) & W'($urandom);
         c  = ($urandom_range(0, 15) == 0);
         rd = ($urandom_range(0, 2) != 0);
         cyc(r, c, rd);
         if ($urandom_range(0, 79) == 0) begin
            rst = 1'b0;
            #1;
            model_reset();
            check_all("rst_mid");
            rst = 1'b1;
         end
      end

      // Full vector drains one index per cycle.
      cyc(8'hFF, 1'b0, 1'b1);
      for (int i = 0; i < W; i++) cyc(8'h00, 1'b0, 1'b1);
      chk_eq("drain_empty", 32'(valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_prio_event_enc
